encoder_83_sync: RTL
====================

Name: encoder_83_sync

Overview:
- Registered 8-to-3 priority encoder with sticky request capture and a valid/ack handshake.
- Converts one-hot-or-more request lines back to a 3-bit index. It is the return path for decoder_83: lines expanded by the decoder are encoded back to an index.
- Requests are latched into a pending register and served one at a time, in priority order, until the consumer acknowledges each one.
- Sits between discrete request sources (e.g. decoded select lines, interrupt-like strobes) and a single downstream consumer.

Parameters:
- HIGH_FIRST, 1, priority direction. 1 = index 7 highest priority; 0 = index 0 highest.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- e    input  1  capture enable. 1 = new requests on d are captured; 0 = d is ignored.
- d    input  8  request lines; d[j] high = request for index j (level, sampled each edge).
- ack  input  1  consumer accepts the current y; meaningful only while v=1.
- y    output 3  encoded index of the request being presented.
- v    output 1  y holds a valid request.
- pend output 8  current pending register, for debug and observation.
- ovf  output 1  sticky overflow flag.

Behaviour:
- Reset values: rst=1 at an edge gives pend=0, y=0, v=0, ovf=0. Reset has priority over every other input, including mid-handshake: a pending or presented request is dropped, no ack is needed.
- Acknowledge:
  - take = v & ack.
  - clr = one-hot of y when take=1, else 0.
- Pending update at each edge: pend_n = (pend & ~clr) | (e ? d : 8'h00).
- Re-request on ack: if d[y] is high in the same edge as its ack, that bit stays pending. It counts as a new request and may be presented again.
- Overflow: ovf is set when e=1 and d[j]=1 while pend[j]=1 and clr[j]=0 (a request merged into an unserved one). It stays 1 until rst.
- State machine, 2 states (held in v):
  - IDLE (v=0): at the edge, if pend_n != 0 then load y = sel(pend_n) and go to PRESENT. Otherwise stay in IDLE, y holds its last value.
  - PRESENT (v=1), ack=0: y and v hold, even if a higher-priority request arrives (y is stable until accepted).
  - PRESENT, ack=1: if pend_n != 0 then load y = sel(pend_n) and stay in PRESENT (back-to-back service, v stays 1). Otherwise go to IDLE (v=0).
- sel(): index of the highest-priority set bit per HIGH_FIRST.
- Latency: a request on d sampled at edge k (while IDLE) gives v=1 and y valid after edge k. Throughput is one request per cycle with ack held high.
- e=0: already-pending requests are still served; no new captures; no overflow detection.
- ack while v=0: ignored.
- Bits: each pend bit is served exactly once per capture. No wrap-around or counters beyond pend.

Decomposition:
- Shared package: IDX_W=3, REQ_W=8 constants.
- Shared package: function prio_sel(req, high_first) returning a 3-bit index; it also serves any future encoder.
- One natural sub-module, prio_enc_8: a combinational sel() wrapper. The registered top holds pend/y/v/ovf.

Test Plan:
- Reset: rst=1 for 2 cycles with d=8'hFF, e=1 → pend=0, v=0, y=0, ovf=0. Release rst, ack=0 → next edge v=1, y=7, pend=8'hFF.
- Priority drain: d=8'b1010_0100 for one cycle, e=1, then ack=1 held → y sequence 7,5,2 on consecutive cycles with v=1. Then v=0, pend=0. Repeat with HIGH_FIRST=0 → y sequence 2,5,7.
- Hold stability: present y=3, ack=0, then pulse d[6] → y stays 3 and v=1. After ack → y=6 next cycle.
- Same-edge re-request: y=4, v=1, ack=1 with d=8'h10 in the same cycle → pend[4] stays 1, v=1, y=4 again, ovf=0.
- Overflow and enable: d[1] pulsed twice while y=5 is held unacked → ovf=1 (sticky). With e=0, pulse d[0] → pend[0] stays 0 and ovf is unchanged.
- Mid-operation reset: v=1, pend=8'h0C, rst=1 for one edge → v=0, pend=0, ovf=0. A subsequent ack is ignored.

Source files
------------

// File: rtl/encoder_83_sync_pkg.sv
// ---------------------------------------------------------------------------
// encoder_83_sync_pkg
// Shared constants, state type and priority-select helper for the 8-to-3
// encoder family. The priority function is kept here so that any future
// encoder of this width can reuse the same selection rule.
// ---------------------------------------------------------------------------
package encoder_83_sync_pkg;

    localparam int IDX_W = 3;
    localparam int REQ_W = 8;

    // Handshake state. The encoding equals the valid output, so v is simply
    // the state register.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Index of the highest-priority set bit in req. With high_first=1 the
    // highest index wins; with high_first=0 the lowest index wins. The scan
    // order is chosen so that the winning bit is the last one assigned.
    // Returns 0 when req is empty; callers gate on |req.
    function automatic logic [IDX_W-1:0] prio_sel(input logic [REQ_W-1:0] req,
                                                   input logic             high_first);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (high_first) begin
            for (int j = 0; j < REQ_W; j++) begin
                if (req[j]) idx = IDX_W'(j);
            end
        end else begin
            for (int j = REQ_W - 1; j >= 0; j--) begin
                if (req[j]) idx = IDX_W'(j);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/encoder_83_sync_prio_enc_8.sv
// ---------------------------------------------------------------------------
// prio_enc_8
// Combinational 8-input priority encoder.
//   req_i : request vector
//   idx_o : index of the highest-priority set bit (0 when req_i is empty)
//   any_o : at least one request is set
// HIGH_FIRST selects whether index 7 (1) or index 0 (0) has top priority.
// ---------------------------------------------------------------------------
module prio_enc_8
    import encoder_83_sync_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    assign idx_o = prio_sel(req_i, HIGH_FIRST);
    assign any_o = |req_i;

endmodule

// File: rtl/encoder_83_sync.sv
// ---------------------------------------------------------------------------
// encoder_83_sync
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ack handshake. Requests on d are OR-ed into a pending register and
// presented one at a time on y (highest priority first) until acknowledged.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   e    : capture enable for d
//   d    : request lines, bit j requests index j
//   ack  : consumer accepts the current y (only while v=1)
//   y    : index being presented
//   v    : y holds a valid request
//   pend : pending request register (observation)
//   ovf  : sticky flag, a request landed on a still-unserved pending bit
// ---------------------------------------------------------------------------
module encoder_83_sync
    import encoder_83_sync_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [REQ_W-1:0] d,
    input  logic             ack,
    output logic [IDX_W-1:0] y,
    output logic             v,
    output logic [REQ_W-1:0] pend,
    output logic             ovf
);

    state_e           state_q;
    logic [IDX_W-1:0] y_q;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;

    logic             take;
    logic [REQ_W-1:0] clr;
    logic [REQ_W-1:0] capt;
    logic [IDX_W-1:0] selIdx;
    logic             selAny;

    // An accepted request clears its own pending bit. A fresh capture of the
    // same bit in the same edge re-sets it, so it is served again; that case
    // is a new request rather than a collision, hence clr is excluded from
    // the overflow test.
    always_comb begin
        take   = (state_q == PRESENT) && ack;
        clr    = take ? (REQ_W'(1) << y_q) : '0;
        capt   = e ? d : '0;
        pend_d = (pend_q & ~clr) | capt;
        ovf_d  = ovf_q | (|(capt & pend_q & ~clr));
    end

    // Selection is made on the next pending value so a request captured at
    // an edge while idle is presented right after that same edge.
    prio_enc_8 #(
        .HIGH_FIRST(HIGH_FIRST)
    ) u_prio (
        .req_i(pend_d),
        .idx_o(selIdx),
        .any_o(selAny)
    );

    // Handshake FSM with registered outputs. While PRESENT without ack, y is
    // frozen even if a higher-priority request arrives, so the consumer sees
    // a stable value until it accepts it. On ack the next request (if any)
    // is loaded back-to-back without dropping v.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (selAny) begin
                        y_q     <= selIdx;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        if (selAny) begin
                            y_q <= selIdx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign y    = y_q;
    assign v    = (state_q == PRESENT);
    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule
